seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the board's multiplexed 4-digit seven-segment display driver.
- Samples the scanned AN/SEGMENT lines and rebuilds the 16-bit hex value and 4 decimal points being shown, one frame per complete scan.
- Used as a loopback/self-check monitor on the Top-level display bus and as the bench-side checker for display drivers.

Parameters:
- STABLE_CYC, 4: consecutive identical-input cycles required before a digit is accepted (min 2).
- TIMEOUT_CYC, 1048576: cycles with no accepted digit before stalled asserts.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- AN  input  4  anode selects, active-low, one-hot-low when valid; AN[3] is the leftmost digit.
- SEGMENT  input  8  active-low segments; [0]=a … [6]=g, [7]=dp.
- Hexs  output  16  last complete frame; AN[3] digit → Hexs[15:12] … AN[0] digit → Hexs[3:0].
- Point  output  4  last frame's decimal points, active-high; Point[i] belongs to AN[i].
- frame_valid  output  1  one-cycle pulse when Hexs/Point/pattern_err update.
- pattern_err  output  1  last frame contained ≥1 undecodable segment pattern.
- bad_anode  output  1  sticky; set when more than one AN bit is low.
- stalled  output  1  level; no digit accepted for TIMEOUT_CYC cycles.

Behaviour:
- Reset (rst=0 at a clk edge): Hexs=0, Point=0, frame_valid=0, pattern_err=0, bad_anode=0, stalled=0. The seen-mask, per-digit buffers, stability counter and timeout counter are cleared. Reset mid-frame discards the partial frame.
- Input register: AN and SEGMENT are registered once (prev). run_cnt increments while {AN,SEGMENT}=={prev}; it clears to 0 on any change, saturates at STABLE_CYC-1, and a "taken" flag blocks repeat capture in the same run.
- Legal anode: exactly one AN bit low. All-high (blank) is never captured and leaves bad_anode unchanged. Two or more low sets bad_anode (cleared only by reset) and is never captured.
- Capture: on the edge where run_cnt reaches STABLE_CYC-1 with a legal anode and taken=0, set seen[i]=1 and store the nibble, dp=~SEGMENT[7] and err for digit i. A repeat of an already-seen digit overwrites its buffer.
- Decode uses g..a active-high = ~SEGMENT[6:0]:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Any other pattern gives nibble 0 with err=1.
- Frame completion: on the clk edge after seen becomes 4'b1111:
  - Hexs, Point and pattern_err (OR of the four err bits) load.
  - frame_valid=1 for exactly one cycle.
  - seen clears.
  - A capture on that same edge is counted toward the new frame.
- Latency: digit stable at cycle t is captured at edge t+STABLE_CYC. frame_valid follows the last digit's capture by 1 cycle.
- Timeout: counter clears on every capture and otherwise increments, saturating. stalled=1 while the counter ≥ TIMEOUT_CYC-1; it drops on the cycle after the next capture.
- Outputs are registered; no combinational input-to-output path.
- Hexs/Point hold between frames.

Test Plan:
- Scan value 16'h1A2F, no dp, each digit held 8 cycles, order AN=0111,1011,1101,1110 → after the 4th capture frame_valid pulses once; Hexs=16'h1A2F, Point=0, pattern_err=0.
- Digit held only 3 cycles (STABLE_CYC=4), interleaved with valid digits → glitch digit never captured; frame completes only when every digit has been held ≥4 cycles.
- AN=1110 with SEGMENT=8'h7F (dp lit, segments off, pattern 00) in an otherwise valid frame "8,8,8,x" → Hexs=16'h8880, Point=4'b0001, pattern_err=1.
- AN=1100 held 10 cycles → bad_anode=1 and stays 1; seen unchanged. After a legal frame, frame_valid still pulses.
- Rst driven low after 2 of 4 digits, then released, then a full scan of 16'h0000 → a single frame_valid with Hexs=0. The pre-reset digits are not merged into the frame.
- TIMEOUT_CYC=64, AN held 4'b1111 for 70 cycles → stalled=1 from cycle 64. The next accepted digit drops it 1 cycle after capture.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Rebuilds the hex value and decimal points shown on a multiplexed 4-digit seven-segment bus.
// A digit is accepted once its anode/segment lines hold steady; a frame completes once all
// four digits have been seen.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEGMENT,
  output logic [15:0] Hexs,
  output logic [3:0]  Point,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic        bad_anode,
  output logic        stalled
);

  localparam int unsigned RunW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [RunW-1:0] RunMax = RunW'(STABLE_CYC - 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC - 1);

  logic [3:0]       an_prev_q, an_prev_d;
  logic [7:0]       seg_prev_q, seg_prev_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic             taken_q, taken_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  nib_q, nib_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       err_q, err_d;
  logic [15:0]      hexs_q, hexs_d;
  logic [3:0]       point_q, point_d;
  logic             frame_valid_q, frame_valid_d;
  logic             pattern_err_q, pattern_err_d;
  logic             bad_anode_q, bad_anode_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             stalled_q, stalled_d;

  logic       same, legal, capture, frame_done;
  logic [1:0] dig_idx;
  logic [3:0] dec_nib;
  logic       dec_err;

  // Segment lines are active-low; the table is in g..a active-high form.
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (~SEGMENT[6:0])
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    dig_idx = 2'd0;
    unique case (AN)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  always_comb begin
    same  = ({AN, SEGMENT} == {an_prev_q, seg_prev_q});
    legal = $onehot(~AN);

    an_prev_d  = AN;
    seg_prev_d = SEGMENT;

    run_cnt_d = '0;
    taken_d   = 1'b0;
    if (same) begin
      run_cnt_d = (run_cnt_q == RunMax) ? RunMax : run_cnt_q + RunW'(1);
      taken_d   = taken_q | (run_cnt_d == RunMax);
    end
    capture = same && (run_cnt_d == RunMax) && !taken_q && legal;

    // A capture on the completion edge belongs to the next frame.
    frame_done = (seen_q == 4'hF);
    seen_d = frame_done ? 4'h0 : seen_q;
    nib_d  = nib_q;
    dp_d   = dp_q;
    err_d  = err_q;
    if (capture) begin
      seen_d[dig_idx] = 1'b1;
      nib_d[dig_idx]  = dec_nib;
      dp_d[dig_idx]   = ~SEGMENT[7];
      err_d[dig_idx]  = dec_err;
    end

    hexs_d        = hexs_q;
    point_d       = point_q;
    pattern_err_d = pattern_err_q;
    frame_valid_d = frame_done;
    if (frame_done) begin
      hexs_d        = nib_q;
      point_d       = dp_q;
      pattern_err_d = |err_q;
    end

    bad_anode_d = bad_anode_q | !$onehot0(~AN);

    tmo_d     = capture ? '0 : ((tmo_q == TmoMax) ? tmo_q : tmo_q + TmoW'(1));
    stalled_d = (tmo_q == TmoMax);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      an_prev_q     <= 4'hF;
      seg_prev_q    <= 8'hFF;
      run_cnt_q     <= '0;
      taken_q       <= 1'b0;
      seen_q        <= 4'h0;
      nib_q         <= '0;
      dp_q          <= 4'h0;
      err_q         <= 4'h0;
      hexs_q        <= 16'h0;
      point_q       <= 4'h0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      bad_anode_q   <= 1'b0;
      tmo_q         <= '0;
      stalled_q     <= 1'b0;
    end else begin
      an_prev_q     <= an_prev_d;
      seg_prev_q    <= seg_prev_d;
      run_cnt_q     <= run_cnt_d;
      taken_q       <= taken_d;
      seen_q        <= seen_d;
      nib_q         <= nib_d;
      dp_q          <= dp_d;
      err_q         <= err_d;
      hexs_q        <= hexs_d;
      point_q       <= point_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
      bad_anode_q   <= bad_anode_d;
      tmo_q         <= tmo_d;
      stalled_q     <= stalled_d;
    end
  end

  assign Hexs        = hexs_q;
  assign Point       = point_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;
  assign bad_anode   = bad_anode_q;
  assign stalled     = stalled_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: digit-level reference model feeds a frame scoreboard,
// directed scenarios followed by randomized scanning.
module tb_seg_scan_decoder;

  localparam int unsigned Stable  = 4;
  localparam int unsigned Timeout = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  AN = 4'hF;
  logic [7:0]  SEGMENT = 8'hFF;
  logic [15:0] Hexs;
  logic [3:0]  Point;
  logic        frame_valid, pattern_err, bad_anode, stalled;

  seg_scan_decoder #(
    .STABLE_CYC (Stable),
    .TIMEOUT_CYC(Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .Hexs       (Hexs),
    .Point      (Point),
    .frame_valid(frame_valid),
    .pattern_err(pattern_err),
    .bad_anode  (bad_anode),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // g..a active-high glyphs for 0..F
  logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [15:0] hexs;
    logic [3:0]  point;
    logic        err;
    int          cyc;
  } frame_t;
  frame_t exp_q[$];

  // Reference model state, kept at digit granularity
  logic [11:0] m_prev;
  int          m_run;
  bit          m_taken;
  bit          m_bad;
  bit [3:0]    m_seen;
  logic [3:0]  m_nib [4];
  bit          m_dp [4];
  bit          m_err [4];

  function automatic int lows(input logic [3:0] an);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] nib, input bit dp);
    logic [6:0] p;
    p = pat_tbl[nib];
    return ~{dp, p};
  endfunction

  task automatic model_reset();
    m_prev  = 12'hFFF;
    m_run   = 0;
    m_taken = 0;
    m_bad   = 0;
    m_seen  = '0;
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = 0; m_dp[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_capture(input logic [3:0] an, input logic [7:0] seg, input int cap_cyc);
    int idx = 0;
    bit hit = 0;
    frame_t f;
    for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
    m_nib[idx] = 0;
    for (int k = 0; k < 16; k++) begin
      if (pat_tbl[k] == ~seg[6:0]) begin
        m_nib[idx] = k[3:0];
        hit = 1;
      end
    end
    m_err[idx]  = !hit;
    m_dp[idx]   = !seg[7];
    m_seen[idx] = 1;
    if (m_seen == 4'hF) begin
      f.hexs  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      f.point = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      f.err   = m_err[0] | m_err[1] | m_err[2] | m_err[3];
      f.cyc   = cap_cyc + 1;
      exp_q.push_back(f);
      m_seen = '0;
    end
  endtask

  // Called with the inputs about to be held for 'hold' edges, starting after edge 'cyc'
  task automatic model_step(input logic [3:0] an, input logic [7:0] seg, input int hold);
    int base;
    if ({an, seg} == m_prev) base = m_run;
    else begin
      base    = 0;
      m_taken = 0;
    end
    m_run  = base + hold;
    m_prev = {an, seg};
    if (lows(an) >= 2 && hold > 0) m_bad = 1;
    if (!m_taken && m_run >= int'(Stable)) begin
      m_taken = 1;
      if (lows(an) == 1) model_capture(an, seg, cyc + int'(Stable) - base);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int hold);
    model_step(an, seg, hold);
    AN      = an;
    SEGMENT = seg;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic digit(input int pos, input logic [3:0] nib, input bit dp, input int hold);
    logic [3:0] an;
    an = 4'hF;
    an[pos] = 1'b0;
    drive(an, seg_of(nib, dp), hold);
  endtask

  task automatic do_reset();
    drive(4'hF, 8'hFF, 3);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Frame monitor
  always @(negedge clk) begin
    if (rst && frame_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        chk("frame_cycle", cyc, f.cyc);
        chk("Hexs", Hexs, f.hexs);
        chk("Point", Point, f.point);
        chk("pattern_err", pattern_err, f.err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nibs;
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_Hexs", Hexs, 0);
    chk("rst_Point", Point, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_pattern_err", pattern_err, 0);
    chk("rst_bad_anode", bad_anode, 0);
    chk("rst_stalled", stalled, 0);

    // 16'h1A2F, left to right, 8 cycles each
    digit(3, 4'h1, 0, 8);
    digit(2, 4'hA, 0, 8);
    digit(1, 4'h2, 0, 8);
    digit(0, 4'hF, 0, 8);
    drive(4'hF, 8'hFF, 4);

    // Short glitches interleaved with held digits
    digit(3, 4'h5, 0, 5);
    digit(2, 4'h9, 1, 3);
    digit(1, 4'h3, 0, 4);
    digit(2, 4'h7, 0, 2);
    digit(0, 4'hC, 0, 6);
    digit(2, 4'h6, 0, 4);
    drive(4'hF, 8'hFF, 4);

    // Undecodable pattern with dp lit on the rightmost digit
    digit(3, 4'h8, 0, 5);
    digit(2, 4'h8, 0, 5);
    digit(1, 4'h8, 0, 5);
    drive(4'b1110, 8'h7F, 5);
    drive(4'hF, 8'hFF, 4);

    // Two anodes low is flagged, sticky, and never captured
    digit(3, 4'h4, 0, 5);
    drive(4'b1100, seg_of(4'h2, 0), 10);
    chk("bad_anode_set", bad_anode, 1);
    digit(2, 4'hD, 0, 5);
    digit(1, 4'hE, 1, 5);
    digit(0, 4'hB, 0, 5);
    chk("bad_anode_sticky", bad_anode, 1);
    drive(4'hF, 8'hFF, 4);

    // Reset mid-frame discards the partial frame
    digit(3, 4'h3, 0, 5);
    digit(2, 4'h3, 0, 5);
    do_reset();
    chk("midrst_Hexs", Hexs, 0);
    chk("midrst_bad_anode", bad_anode, 0);
    for (int i = 3; i >= 0; i--) digit(i, 4'h0, 0, 5);
    drive(4'hF, 8'hFF, 4);

    // Stall: blank right after reset
    do_reset();
    drive(4'hF, 8'hFF, Timeout - 1);
    chk("stall_before", stalled, 0);
    drive(4'hF, 8'hFF, 1);
    chk("stall_at_timeout", stalled, 1);
    drive(4'hF, 8'hFF, 6);
    digit(1, 4'h7, 0, int'(Stable) - 1);
    chk("stall_pre_capture", stalled, 1);
    digit(1, 4'h7, 0, 1);
    chk("stall_at_capture", stalled, 1);
    digit(1, 4'h7, 0, 1);
    chk("stall_cleared", stalled, 0);

    // Randomized scanning
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      nibs = 4'($urandom_range(0, 15));
      if (r < 70) begin
        digit($urandom_range(0, 3), nibs, 1'($urandom_range(0, 1)), $urandom_range(4, 7));
      end else if (r < 80) begin
        digit($urandom_range(0, 3), nibs, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else if (r < 88) begin
        drive(4'hF, 8'hFF, $urandom_range(1, 5));
      end else if (r < 96) begin
        logic [3:0] an;
        an = 4'hF;
        an[$urandom_range(0, 3)] = 1'b0;
        drive(an, 8'($urandom), $urandom_range(3, 6));
      end else begin
        drive(4'($urandom_range(0, 15)) & 4'b0110 | 4'b1001 & 4'b0110 ^ 4'b1001,
              8'($urandom), $urandom_range(2, 5));
      end
    end
    drive(4'hF, 8'hFF, 10);

    chk("pending_frames", exp_q.size(), 0);
    chk("final_bad_anode", bad_anode, m_bad);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
